// File: rtl/segasys1_sndcmd.sv
// Sound-command mailbox between the main CPU and the sound CPU with NMI handshake.
// Define SEGASYS1_SNDFIFO_EN for a 4-entry queue; otherwise a single overwriting latch.
module segasys1_sndcmd #(
  parameter int HOLD_CYC = 16
) (
  input  logic       CLK48M,
  input  logic       RESET,
  input  logic       MWR,
  input  logic [7:0] MDATA,
  input  logic       SRD,
  output logic [7:0] SDATA,
  output logic       SNMI,
  output logic       PEND,
  output logic [2:0] COUNT,
  output logic       OVF,
  input  logic       OVF_CLR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  logic          mwr_q, srd_q, rst_q;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [2:0]    count_q, count_d;
  logic [7:0]    sdata_q, sdata_d;
  logic          snmi_q, snmi_d;
  logic          pend_q, ovf_q, ovf_d;

  logic          mwr_edge_s, srd_edge_s, pop_s, push_ok_s, ovf_set_s;
  logic [7:0]    head_s;

  // rst_q masks the first cycle after reset so a level already high is not an edge
  assign mwr_edge_s = MWR & ~mwr_q & ~rst_q;
  assign srd_edge_s = SRD & ~srd_q & ~rst_q;
  assign pop_s      = srd_edge_s & (state_q == ST_ASSERT);

`ifdef SEGASYS1_SNDFIFO_EN
  logic [7:0] mem_q [4];
  logic [1:0] wp_q, rp_q;
  logic       full_s;

  assign full_s    = (count_q == 3'd4);
  assign push_ok_s = mwr_edge_s & (~full_s | pop_s);
  assign ovf_set_s = mwr_edge_s & full_s & ~pop_s;
  assign head_s    = mem_q[rp_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK48M) begin
    if (RESET) begin
      wp_q <= 2'd0;
      rp_q <= 2'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
    end else begin
      if (push_ok_s) begin
        mem_q[wp_q] <= MDATA;
        wp_q        <= wp_q + 2'd1;
      end
      if (pop_s) rp_q <= rp_q + 2'd1;
    end
  end
`else
  logic [7:0] byte_q;

  assign push_ok_s = mwr_edge_s;
  assign ovf_set_s = mwr_edge_s & count_q[0] & ~pop_s;
  assign head_s    = byte_q;

  always_comb begin
    count_d = count_q;
    if (push_ok_s)  count_d = 3'd1;
    else if (pop_s) count_d = 3'd0;
    else            count_d = count_q;
  end

  always_ff @(posedge CLK48M) begin
    if (RESET)          byte_q <= 8'h00;
    else if (push_ok_s) byte_q <= MDATA;
    else                byte_q <= byte_q;
  end
`endif

  assign ovf_d = ovf_set_s | (ovf_q & ~OVF_CLR);

  // SDATA tracks the head only while asserting; otherwise it keeps the last byte shown
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    snmi_d  = snmi_q;
    sdata_d = sdata_q;
    case (state_q)
      ST_IDLE: begin
        snmi_d = 1'b0;
        if (count_q != 3'd0) begin
          state_d = ST_ASSERT;
          snmi_d  = 1'b1;
          sdata_d = head_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (pop_s) begin
          state_d = ST_HOLD;
          snmi_d  = 1'b0;
          hold_d  = HOLD_LAST;
        end else begin
          snmi_d  = 1'b1;
          sdata_d = head_s;
        end
      end
      ST_HOLD: begin
        snmi_d = 1'b0;
        if (hold_q == '0) begin
          if (count_q != 3'd0) begin
            state_d = ST_ASSERT;
            snmi_d  = 1'b1;
            sdata_d = head_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        snmi_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK48M) begin
    rst_q <= RESET;
    if (RESET) begin
      mwr_q   <= 1'b0;
      srd_q   <= 1'b0;
      state_q <= ST_IDLE;
      hold_q  <= '0;
      count_q <= 3'd0;
      sdata_q <= 8'h00;
      snmi_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mwr_q   <= MWR;
      srd_q   <= SRD;
      state_q <= state_d;
      hold_q  <= hold_d;
      count_q <= count_d;
      sdata_q <= sdata_d;
      snmi_q  <= snmi_d;
      pend_q  <= (count_d != 3'd0);
      ovf_q   <= ovf_d;
    end
  end

  assign SDATA = sdata_q;
  assign SNMI  = snmi_q;
  assign PEND  = pend_q;
  assign COUNT = count_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// Directed self-checking bench for segasys1_sndcmd (HOLD_CYC = 16).
module tb_segasys1_sndcmd;

  logic       clk = 1'b0;
  logic       RESET, MWR, SRD, OVF_CLR;
  logic [7:0] MDATA;
  logic [7:0] SDATA;
  logic       SNMI, PEND, OVF;
  logic [2:0] COUNT;

  int n_cmp = 0;
  int n_err = 0;
  int gap;
  int bad;

  segasys1_sndcmd #(.HOLD_CYC(16)) dut (
    .CLK48M(clk), .RESET(RESET), .MWR(MWR), .MDATA(MDATA), .SRD(SRD),
    .SDATA(SDATA), .SNMI(SNMI), .PEND(PEND), .COUNT(COUNT), .OVF(OVF),
    .OVF_CLR(OVF_CLR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counts low SNMI samples until it rises, giving up after 60
  task automatic wait_nmi(output int n);
    n = 0;
    while (SNMI == 1'b0 && n < 60) begin
      n++;
      tick();
    end
  endtask

  task automatic push(input logic [7:0] b);
    MWR = 1'b1; MDATA = b; tick();
    MWR = 1'b0; tick();
  endtask

  task automatic pop_and_gap(output int n);
    SRD = 1'b1; tick();
    SRD = 1'b0;
    wait_nmi(n);
  endtask

  initial begin
    RESET = 1'b1; MWR = 1'b0; SRD = 1'b0; OVF_CLR = 1'b0; MDATA = 8'h00;
    tick(); tick();
    check_eq("rst_sdata", 32'(SDATA), 32'h00);
    check_eq("rst_snmi",  32'(SNMI),  32'h0);
    check_eq("rst_pend",  32'(PEND),  32'h0);
    check_eq("rst_count", 32'(COUNT), 32'h0);
    check_eq("rst_ovf",   32'(OVF),   32'h0);
    RESET = 1'b0; tick(); tick();

    // 6-cycle write strobe: one push, NMI one cycle after COUNT
    MWR = 1'b1; MDATA = 8'h5A; tick();
    check_eq("w_count", 32'(COUNT), 32'h1);
    check_eq("w_pend",  32'(PEND),  32'h1);
    check_eq("w_snmi0", 32'(SNMI),  32'h0);
    tick();
    check_eq("w_snmi1", 32'(SNMI),  32'h1);
    check_eq("w_sdata", 32'(SDATA), 32'h5A);
    for (int i = 0; i < 4; i++) tick();
    MWR = 1'b0; tick();
    check_eq("w_once", 32'(COUNT), 32'h1);

    SRD = 1'b1; tick();
    check_eq("r_count", 32'(COUNT), 32'h0);
    check_eq("r_snmi",  32'(SNMI),  32'h0);
    check_eq("r_pend",  32'(PEND),  32'h0);
    tick(); SRD = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (SNMI != 1'b0) bad++;
    end
    check_eq("idle_nmi", 32'(bad), 32'h0);
    check_eq("idle_sdata", 32'(SDATA), 32'h5A);

    // read strobe in IDLE is ignored
    SRD = 1'b1; tick(); SRD = 1'b0; tick();
    check_eq("idle_rd_cnt", 32'(COUNT), 32'h0);

    // HOLD gap length measured by queuing a byte during HOLD
    push(8'h3C);
    check_eq("g_sdata0", 32'(SDATA), 32'h3C);
    SRD = 1'b1; tick();
    check_eq("g_hold_sdata", 32'(SDATA), 32'h3C);
    SRD = 1'b0; MWR = 1'b1; MDATA = 8'h7E;
    gap = 0;
    while (SNMI == 1'b0 && gap < 60) begin
      gap++;
      tick();
      MWR = 1'b0;
    end
    check_eq("g_gap", 32'(gap), 32'd16);
    check_eq("g_sdata1", 32'(SDATA), 32'h7E);

    pop_and_gap(gap);
    check_eq("drain_gap", 32'(gap), 32'd60);

`ifdef SEGASYS1_SNDFIFO_EN
    for (int i = 1; i <= 5; i++) push(8'(i));
    check_eq("f_count", 32'(COUNT), 32'h4);
    check_eq("f_ovf",   32'(OVF),   32'h1);
    for (int i = 1; i <= 4; i++) begin
      check_eq("f_rd_nmi", 32'(SNMI), 32'h1);
      check_eq("f_rd_data", 32'(SDATA), 32'(i));
      pop_and_gap(gap);
      check_eq("f_gap", 32'(gap), (i < 4) ? 32'd16 : 32'd60);
    end
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    check_eq("f_ovf_clr", 32'(OVF), 32'h0);
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    MWR = 1'b1; MDATA = 8'h14; SRD = 1'b1; tick();
    MWR = 1'b0; SRD = 1'b0;
    check_eq("f_pp_count", 32'(COUNT), 32'h4);
    check_eq("f_pp_ovf",   32'(OVF),   32'h0);
    for (int i = 1; i <= 4; i++) begin
      wait_nmi(gap);
      check_eq("f_pp_gap", 32'(gap), 32'd16);
      check_eq("f_pp_data", 32'(SDATA), 32'h10 + 32'(i));
      SRD = 1'b1; tick(); SRD = 1'b0;
    end
`else
    push(8'hA0);
    check_eq("l_sdata0", 32'(SDATA), 32'hA0);
    MWR = 1'b1; MDATA = 8'hA1; tick(); MWR = 1'b0;
    check_eq("l_ovf", 32'(OVF), 32'h1);
    tick();
    check_eq("l_sdata1", 32'(SDATA), 32'hA1);
    check_eq("l_count",  32'(COUNT), 32'h1);
    check_eq("l_nmi",    32'(SNMI),  32'h1);
    tick(); tick();
    check_eq("l_ovf_sticky", 32'(OVF), 32'h1);
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    check_eq("l_ovf_clr", 32'(OVF), 32'h0);
    MWR = 1'b1; MDATA = 8'hB2; OVF_CLR = 1'b1; tick();
    check_eq("l_ovf_win", 32'(OVF), 32'h1);
    MWR = 1'b0; tick(); OVF_CLR = 1'b0;
    check_eq("l_ovf_clr2", 32'(OVF), 32'h0);
    check_eq("l_sdata2", 32'(SDATA), 32'hB2);
`endif

    // reset during HOLD with a command queued, strobes high across release
    SRD = 1'b1; tick(); SRD = 1'b0; tick();
    MWR = 1'b1; MDATA = 8'hC1; tick(); MWR = 1'b0;
    tick(); tick();
    check_eq("h_count", 32'(COUNT), 32'h1);
    RESET = 1'b1; MWR = 1'b1; SRD = 1'b1; tick();
    check_eq("h_rst_sdata", 32'(SDATA), 32'h00);
    check_eq("h_rst_snmi",  32'(SNMI),  32'h0);
    check_eq("h_rst_count", 32'(COUNT), 32'h0);
    check_eq("h_rst_pend",  32'(PEND),  32'h0);
    RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (SNMI != 1'b0 || COUNT != 3'd0) bad++;
    end
    check_eq("h_no_edge", 32'(bad), 32'h0);
    MWR = 1'b0; SRD = 1'b0; tick();
    push(8'hD2);
    check_eq("h_after_nmi",  32'(SNMI),  32'h1);
    check_eq("h_after_data", 32'(SDATA), 32'hD2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
